rc4_prga_engine: RTL and testbench
==================================

Name: rc4_prga_engine

Overview:
Parametrised RC4 keystream (PRGA) and decrypt engine, next generation of the existing decryption FSM. It performs real in-memory swaps of S over a single-port synchronous S RAM, and reads ciphertext from a synchronous ROM. Each plaintext byte is written to a result RAM. Optional per-byte plaintext validity check aborts early on an illegal character, so the key-search controller can move to the next key without finishing the message.

Parameters:
MSG_DEP, 32, message length in bytes (1..2^ADDR_W).
DATA_W, 8, byte width of S, ciphertext and plaintext.
ADDR_W, 8, S address width; S depth = 2^ADDR_W; all i/j/index arithmetic is modulo 2^ADDR_W.
K_W, 5, message index width (>= clog2(MSG_DEP)).
CHECK_EN, 1, 1 = abort on invalid plaintext byte; 0 = decrypt the full message and never abort.
LO_CHAR, 8'h61, lowest legal character.
HI_CHAR, 8'h7A, highest legal character.
SP_CHAR, 8'h20, additional legal character.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request to begin; sampled only in IDLE.
s_addr  out  ADDR_W  S RAM address.
s_wdata  out  DATA_W  S RAM write data.
s_we  out  1  S RAM write enable.
s_rdata  in  DATA_W  S RAM read data, valid 1 cycle after the address is presented.
rom_addr  out  K_W  ciphertext ROM address.
rom_rdata  in  DATA_W  ciphertext byte, 1-cycle latency.
dec_addr  out  K_W  result RAM address.
dec_wdata  out  DATA_W  plaintext byte.
dec_we  out  1  result RAM write enable.
busy  out  1  high from the cycle after start is accepted until DONE.
done  out  1  held high in DONE until the next accepted start.
ok  out  1  valid while done is high: 1 = all MSG_DEP bytes legal (or CHECK_EN=0); 0 = aborted.

Behaviour:
- Reset (any time, including mid-message): state goes to IDLE; i, j, k, si, sj and f are cleared; s_we, dec_we, busy, done and ok are all 0. S and result RAM contents are left as they are. The caller must rerun key scheduling before the next start.
- Memory-interface outputs are decoded combinationally from the state and registers (Moore style). s_we and dec_we are high for exactly one cycle per write.
- rom_addr = k in every state.
- States and actions per byte k (9 cycles/byte):
  - IDLE: on start, clear i, j, k, done, ok; go to RD_I. start while not in IDLE is ignored.
  - RD_I: s_addr = i+1; register i <= i+1.
  - GET_I: si <= s_rdata; j <= j + s_rdata.
  - RD_J: s_addr = j.
  - GET_J: sj <= s_rdata.
  - WR_J: s_addr = j, s_wdata = si, s_we = 1.
  - WR_I: s_addr = i, s_wdata = sj, s_we = 1.
  - RD_F: s_addr = si + sj (mod 2^ADDR_W).
  - GET_F: f <= s_rdata. rom_rdata is also valid here.
  - WR_OUT: dec_addr = k, dec_wdata = f ^ rom_rdata, dec_we = 1.
    - If CHECK_EN and the byte is illegal: ok <= 0, go to DONE.
    - Else if k == MSG_DEP-1: ok <= 1, go to DONE.
    - Else k <= k+1, go to RD_I.
  - DONE: done = 1, busy = 0; stays until start, which restarts the sequence from IDLE semantics.
- Legal byte rule: (LO_CHAR <= b <= HI_CHAR) or b == SP_CHAR.
- The illegal byte is still written to the result RAM before the abort.
- When i == j: both writes target the same address with equal data. This is legal and needs no special case.
- i and j wrap modulo 2^ADDR_W with no flag.
- Latency: a full message takes 9*MSG_DEP cycles from the first RD_I to DONE. An abort at byte k takes 9*(k+1) cycles.

Test Plan:
- Identity S (S[x]=x), MSG_DEP=3, ciphertext {63,67,27} -> keystream 02,05,07; result RAM {61,62,20}; ok=1; done after 27 cycles in RD_I..WR_OUT; final S[2]=03, S[3]=05, S[5]=02.
- Same S, ciphertext {63,00,27}, CHECK_EN=1 -> byte1 = 05 is written; ok=0; exactly 2 dec_we pulses; done 18 cycles after start.
- Same as the previous case with CHECK_EN=0 -> 3 writes {61,05,20}; ok=1.
- Assert reset low during WR_J of byte 1 -> outputs immediately 0 and state IDLE. A subsequent start with reinitialised S reproduces the first scenario exactly.
- Pulse start while busy -> ignored; no change to the sequence or result. A start pulse in DONE clears done and ok and reruns.
- MSG_DEP=256, identity S -> i wraps from FF to 00 with no hang; 256 result writes; done asserted exactly 2304 cycles after the first RD_I.

Source files
------------

// File: rtl/rc4_prga_engine.sv
// RC4 keystream generator and decryptor with in-place S swaps over a single-port synchronous RAM.
// 9 cycles per byte; no backpressure, and start is ignored except in IDLE/DONE.
module rc4_prga_engine #(
   parameter int                MSG_DEP  = 32,
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 8,
   parameter int                K_W      = 5,
   parameter bit                CHECK_EN = 1'b1,
   parameter logic [DATA_W-1:0] LO_CHAR  = 8'h61,
   parameter logic [DATA_W-1:0] HI_CHAR  = 8'h7A,
   parameter logic [DATA_W-1:0] SP_CHAR  = 8'h20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   output logic              s_we,
   input  logic [DATA_W-1:0] s_rdata,
   output logic [K_W-1:0]    rom_addr,
   input  logic [DATA_W-1:0] rom_rdata,
   output logic [K_W-1:0]    dec_addr,
   output logic [DATA_W-1:0] dec_wdata,
   output logic              dec_we,
   output logic              busy,
   output logic              done,
   output logic              ok
);

   typedef enum logic [3:0] {
      IDLE, RD_I, GET_I, RD_J, GET_J, WR_J, WR_I, RD_F, GET_F, WR_OUT, DONE
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] i, j;
   logic [K_W-1:0]    k;
   logic [DATA_W-1:0] si, sj, f;
   logic              ok_q;
   logic [DATA_W-1:0] pt;
   logic              pt_legal, abort, last_byte;

   assign pt        = f ^ rom_rdata;
   assign pt_legal  = ((pt >= LO_CHAR) && (pt <= HI_CHAR)) || (pt == SP_CHAR);
   assign abort     = CHECK_EN && !pt_legal;
   assign last_byte = (k == K_W'(MSG_DEP - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = RD_I;
         RD_I:    state_nxt = GET_I;
         GET_I:   state_nxt = RD_J;
         RD_J:    state_nxt = GET_J;
         GET_J:   state_nxt = WR_J;
         WR_J:    state_nxt = WR_I;
         WR_I:    state_nxt = RD_F;
         RD_F:    state_nxt = GET_F;
         GET_F:   state_nxt = WR_OUT;
         WR_OUT:  state_nxt = (abort || last_byte) ? DONE : RD_I;
         DONE:    if (start) state_nxt = RD_I;
         default: state_nxt = IDLE;
      endcase
   end

   // Index, swap-operand and keystream registers; a restart from DONE clears exactly like IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         i    <= '0;
         j    <= '0;
         k    <= '0;
         si   <= '0;
         sj   <= '0;
         f    <= '0;
         ok_q <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  i    <= '0;
                  j    <= '0;
                  k    <= '0;
                  ok_q <= 1'b0;
               end
            end
            RD_I: i <= i + ADDR_W'(1);
            GET_I: begin
               si <= s_rdata;
               j  <= j + ADDR_W'(s_rdata);
            end
            GET_J: sj <= s_rdata;
            GET_F: f  <= s_rdata;
            WR_OUT: begin
               if (abort)          ok_q <= 1'b0;
               else if (last_byte) ok_q <= 1'b1;
               else                k    <= k + K_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      s_addr    = '0;
      s_wdata   = '0;
      s_we      = 1'b0;
      dec_we    = 1'b0;
      unique case (state)
         RD_I:   s_addr = i + ADDR_W'(1);
         RD_J:   s_addr = j;
         WR_J: begin
            s_addr  = j;
            s_wdata = si;
            s_we    = 1'b1;
         end
         WR_I: begin
            s_addr  = i;
            s_wdata = sj;
            s_we    = 1'b1;
         end
         RD_F:   s_addr = ADDR_W'(si) + ADDR_W'(sj);
         WR_OUT: dec_we = 1'b1;
         default: ;
      endcase
   end

   assign rom_addr  = k;
   assign dec_addr  = k;
   assign dec_wdata = pt;
   assign busy      = (state != IDLE) && (state != DONE);
   assign done      = (state == DONE);
   assign ok        = ok_q;

endmodule

// File: tb/tb_rc4_prga_engine.sv
// Bench for rc4_prga_engine: a 3-byte checking instance and a 256-byte non-checking instance,
// scored against a plain RC4 reference model through per-instance write scoreboards.
module tb_rc4_prga_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // Instance A: 256-byte message, no plaintext check
   logic       a_start;
   logic [7:0] a_s_addr, a_s_wdata, a_s_rdata, a_rom_addr, a_rom_rdata, a_dec_addr, a_dec_wdata;
   logic       a_s_we, a_dec_we, a_busy, a_done, a_ok;
   // Instance B: 3-byte message, abort on illegal byte
   logic       b_start;
   logic [7:0] b_s_addr, b_s_wdata, b_s_rdata, b_rom_rdata, b_dec_wdata;
   logic [1:0] b_rom_addr, b_dec_addr;
   logic       b_s_we, b_dec_we, b_busy, b_done, b_ok;

   logic [7:0] a_s [256];
   logic [7:0] a_rom [256];
   logic [7:0] a_res [256];
   logic [7:0] b_s [256];
   logic [7:0] b_rom [4];
   logic [7:0] b_res [4];

   rc4_prga_engine #(.MSG_DEP(256), .K_W(8), .CHECK_EN(1'b0)) u_a (
      .clk(clk), .reset(rst_n), .start(a_start),
      .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_we(a_s_we), .s_rdata(a_s_rdata),
      .rom_addr(a_rom_addr), .rom_rdata(a_rom_rdata),
      .dec_addr(a_dec_addr), .dec_wdata(a_dec_wdata), .dec_we(a_dec_we),
      .busy(a_busy), .done(a_done), .ok(a_ok)
   );

   rc4_prga_engine #(.MSG_DEP(3), .K_W(2), .CHECK_EN(1'b1)) u_b (
      .clk(clk), .reset(rst_n), .start(b_start),
      .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_we(b_s_we), .s_rdata(b_s_rdata),
      .rom_addr(b_rom_addr), .rom_rdata(b_rom_rdata),
      .dec_addr(b_dec_addr), .dec_wdata(b_dec_wdata), .dec_we(b_dec_we),
      .busy(b_busy), .done(b_done), .ok(b_ok)
   );

   always @(posedge clk) begin
      if (a_s_we) a_s[a_s_addr] = a_s_wdata;
      if (a_dec_we) a_res[a_dec_addr] = a_dec_wdata;
      a_s_rdata   <= a_s[a_s_addr];
      a_rom_rdata <= a_rom[a_rom_addr];
   end

   always @(posedge clk) begin
      if (b_s_we) b_s[b_s_addr] = b_s_wdata;
      if (b_dec_we) b_res[b_dec_addr] = b_dec_wdata;
      b_s_rdata   <= b_s[b_s_addr];
      b_rom_rdata <= b_rom[b_rom_addr];
   end

   typedef struct packed { logic [7:0] addr; logic [7:0] dat; } wr_t;
   wr_t qa[$];
   wr_t qb[$];
   int n_vec = 0, n_miss = 0;
   int a_cyc = 0, a_wr = 0, b_cyc = 0, b_wr = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      wr_t e;
      if (a_busy) a_cyc++;
      if (a_dec_we) begin
         a_wr++;
         if (qa.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL a_extra_write: addr %0h data %0h, no write expected", a_dec_addr, a_dec_wdata);
         end else begin
            e = qa.pop_front();
            chk("a_dec_addr", a_dec_addr, e.addr);
            chk("a_dec_wdata", a_dec_wdata, e.dat);
         end
      end
   end

   always @(negedge clk) begin
      wr_t e;
      if (b_busy) b_cyc++;
      if (b_dec_we) begin
         b_wr++;
         if (qb.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL b_extra_write: addr %0h data %0h, no write expected", b_dec_addr, b_dec_wdata);
         end else begin
            e = qb.pop_front();
            chk("b_dec_addr", b_dec_addr, e.addr);
            chk("b_dec_wdata", b_dec_wdata, e.dat);
         end
      end
   end

   // Reference model: textbook RC4 PRGA over a byte array, XOR with ciphertext, optional early stop.
   logic [7:0] ms [256];
   logic [7:0] mc [256];
   logic [7:0] mp [$];
   bit         m_ok;

   function automatic bit legal(input logic [7:0] b);
      return (b >= 8'h61 && b <= 8'h7a) || b == 8'h20;
   endfunction

   task automatic ref_run(input int dep, input bit check);
      int ii = 0, jj = 0;
      logic [7:0] t, p;
      mp.delete();
      m_ok = 1'b1;
      for (int kk = 0; kk < dep; kk++) begin
         ii = (ii + 1) % 256;
         jj = (jj + int'(ms[ii])) % 256;
         t = ms[ii]; ms[ii] = ms[jj]; ms[jj] = t;
         p = ms[(int'(ms[ii]) + int'(ms[jj])) % 256] ^ mc[kk];
         mp.push_back(p);
         if (check && !legal(p)) begin
            m_ok = 1'b0;
            break;
         end
      end
   endtask

   task automatic arm(input bit inst);
      int dep;
      dep = inst ? 3 : 256;
      for (int x = 0; x < 256; x++) begin
         ms[x] = inst ? b_s[x] : a_s[x];
         mc[x] = 8'h00;
      end
      for (int x = 0; x < dep; x++) begin
         if (inst) mc[x] = b_rom[x];
         else      mc[x] = a_rom[x];
      end
      ref_run(dep, inst);
      for (int x = 0; x < mp.size(); x++) begin
         if (inst) qb.push_back('{addr: 8'(x), dat: mp[x]});
         else      qa.push_back('{addr: 8'(x), dat: mp[x]});
      end
   endtask

   task automatic set_start(input bit inst, input logic v);
      if (inst) b_start = v;
      else      a_start = v;
   endtask

   function automatic logic bsy(input bit inst); return inst ? b_busy : a_busy; endfunction
   function automatic logic dn(input bit inst);  return inst ? b_done : a_done; endfunction
   function automatic logic okv(input bit inst); return inst ? b_ok : a_ok;     endfunction

   task automatic exec(input bit inst, input int mid);
      int c0, w0, n, mism;
      c0 = inst ? b_cyc : a_cyc;
      w0 = inst ? b_wr : a_wr;
      @(negedge clk); set_start(inst, 1'b1);
      @(negedge clk); set_start(inst, 1'b0);
      chk("busy_after_start", bsy(inst), 1);
      chk("done_cleared_on_start", dn(inst), 0);
      chk("ok_cleared_on_start", okv(inst), 0);
      n = 0;
      while (!dn(inst) && n < 3000) begin
         @(negedge clk);
         set_start(inst, n == mid);
         n++;
      end
      set_start(inst, 1'b0);
      chk("done_reached", dn(inst), 1);
      chk("ok_result", okv(inst), m_ok);
      chk("busy_cycles", (inst ? b_cyc : a_cyc) - c0, 9 * mp.size());
      chk("dec_write_count", (inst ? b_wr : a_wr) - w0, mp.size());
      chk("scoreboard_drained", inst ? qb.size() : qa.size(), 0);
      mism = 0;
      for (int x = 0; x < 256; x++)
         if ((inst ? b_s[x] : a_s[x]) !== ms[x]) mism++;
      chk("s_final_mismatches", mism, 0);
   endtask

   task automatic ident_b();
      for (int x = 0; x < 256; x++) b_s[x] = 8'(x);
   endtask

   task automatic rom_b(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
      b_rom[0] = c0; b_rom[1] = c1; b_rom[2] = c2; b_rom[3] = 8'h00;
   endtask

   task automatic chk_scen1();
      chk("scen1_res0", b_res[0], 8'h61);
      chk("scen1_res1", b_res[1], 8'h62);
      chk("scen1_res2", b_res[2], 8'h20);
      chk("scen1_s2", b_s[2], 8'h03);
      chk("scen1_s3", b_s[3], 8'h05);
      chk("scen1_s5", b_s[5], 8'h02);
   endtask

   function automatic logic [7:0] legal_ch();
      int r;
      r = $urandom_range(0, 26);
      return (r == 26) ? 8'h20 : 8'(8'h61 + r);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int cnt, n;
      a_start = 1'b0;
      b_start = 1'b0;
      rst_n   = 1'b1;
      for (int x = 0; x < 256; x++) begin
         a_s[x] = 8'(x); a_rom[x] = 8'h00; a_res[x] = 8'h00; b_s[x] = 8'(x);
      end
      rom_b(8'h00, 8'h00, 8'h00);
      for (int x = 0; x < 4; x++) b_res[x] = 8'h00;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_b_busy", b_busy, 0);
      chk("rst_b_done", b_done, 0);
      chk("rst_b_ok", b_ok, 0);
      chk("rst_b_s_we", b_s_we, 0);
      chk("rst_b_dec_we", b_dec_we, 0);
      chk("rst_a_busy", a_busy, 0);
      chk("rst_a_done", a_done, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Identity S, ciphertext 63 67 27 -> "ab "
      ident_b(); rom_b(8'h63, 8'h67, 8'h27);
      arm(1); exec(1, -1); chk_scen1();

      // Illegal byte 1 aborts after being written
      ident_b(); rom_b(8'h63, 8'h00, 8'h27);
      for (int x = 0; x < 4; x++) b_res[x] = 8'hee;
      arm(1); exec(1, -1);
      chk("abort_res1", b_res[1], 8'h05);
      chk("abort_res2_untouched", b_res[2], 8'hee);
      chk("abort_ok", b_ok, 0);

      // Reset during WR_J of byte 1, then a clean rerun
      ident_b(); rom_b(8'h63, 8'h67, 8'h27);
      arm(1);
      @(negedge clk); b_start = 1'b1;
      @(negedge clk); b_start = 1'b0;
      cnt = 0; n = 0;
      if (b_s_we) cnt++;
      while (cnt < 3 && n < 100) begin
         @(negedge clk);
         if (b_s_we) cnt++;
         n++;
      end
      chk("reached_wr_j_byte1", cnt, 3);
      rst_n = 1'b0;
      #1;
      chk("midrst_s_we", b_s_we, 0);
      chk("midrst_s_addr", b_s_addr, 0);
      chk("midrst_dec_we", b_dec_we, 0);
      chk("midrst_busy", b_busy, 0);
      chk("midrst_done", b_done, 0);
      qb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ident_b(); rom_b(8'h63, 8'h67, 8'h27);
      arm(1); exec(1, -1); chk_scen1();

      // Start pulse while busy is ignored
      ident_b(); rom_b(8'h63, 8'h67, 8'h27);
      arm(1); exec(1, 10); chk_scen1();

      // Restart straight from DONE with the S left behind
      rom_b(8'($urandom), 8'($urandom), 8'($urandom));
      arm(1); exec(1, -1);

      // Random S; alternate random ciphertext and ciphertext crafted to decrypt legally
      for (int it = 0; it < 24; it++) begin
         for (int x = 0; x < 256; x++) b_s[x] = 8'($urandom);
         if (it % 2 == 1) begin
            for (int x = 0; x < 256; x++) begin ms[x] = b_s[x]; mc[x] = 8'h00; end
            ref_run(3, 1'b0);
            for (int x = 0; x < 3; x++) b_rom[x] = mp[x] ^ legal_ch();
            if (it % 4 == 3) b_rom[$urandom_range(0, 2)] ^= 8'h80;
         end else begin
            rom_b(8'($urandom), 8'($urandom), 8'($urandom));
         end
         arm(1); exec(1, (it % 5 == 0) ? 4 : -1);
      end

      // 256-byte messages: i wraps, every byte written regardless of legality
      for (int x = 0; x < 256; x++) begin a_s[x] = 8'(x); a_rom[x] = 8'($urandom); end
      arm(0); exec(0, -1);
      for (int it = 0; it < 3; it++) begin
         for (int x = 0; x < 256; x++) begin a_s[x] = 8'($urandom); a_rom[x] = 8'($urandom); end
         arm(0); exec(0, (it == 1) ? 100 : -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
